// File: rtl/bus_master_if_pkg.sv
// bus_master_if_pkg: shared types and constants for the master-side bus
// interface. Holds the 2-bit FSM state encodings, the bus direction values
// and the default address/data widths used by bus_master_if.
package bus_master_if_pkg;

  // Default word-address and data widths of the system bus.
  localparam int unsigned BUS_ADDR_W         = 30;
  localparam int unsigned BUS_DATA_W         = 32;

  // Default abort limit for the optional transaction timeout.
  localparam int unsigned BUS_TIMEOUT_CYCLES = 255;

  // Bus direction encoding: the idle (non-owner) value is READ so that the
  // shared direction line stays in its harmless state.
  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  // Requester FSM state encodings.
  typedef enum logic [1:0] {
    BUS_IF_STATE_IDLE   = 2'd0,
    BUS_IF_STATE_REQ    = 2'd1,
    BUS_IF_STATE_ACCESS = 2'd2,
    BUS_IF_STATE_WAIT   = 2'd3
  } bus_if_state_e;

  // True while this master owns the bus data phase (strobe or wait cycles).
  function automatic logic bus_if_owns_bus(input bus_if_state_e s);
    return (s == BUS_IF_STATE_ACCESS) || (s == BUS_IF_STATE_WAIT);
  endfunction

endpackage

// File: rtl/bus_master_if_timeout.sv
// bus_master_if_timeout: transaction watchdog for bus_master_if.
// Only compiled when BUS_IF_TIMEOUT_EN is defined; the default build has no
// watchdog and this file is empty.
//
// The counter is cleared on the cycle the FSM enters ACCESS and advances on
// every ACCESS/WAIT cycle. o_expire is raised during the TIMEOUT_CYCLES-th
// such cycle, so the owner may spend exactly TIMEOUT_CYCLES cycles in the
// data phase before it gives up.
`ifdef BUS_IF_TIMEOUT_EN
module bus_master_if_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count data-phase cycles; saturate at the limit so the count never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_count && (r_cnt == LIMIT);

endmodule
`endif

// File: rtl/bus_master_if.sv
// bus_master_if: master-side requester facing the round-robin bus arbiter.
// Turns one core access into an arbiter request/grant handshake followed by
// a single strobed bus transaction, and returns read data.
//
// Optional feature macro: BUS_IF_TIMEOUT_EN (adds the data-phase watchdog,
// the TIMEOUT_CYCLES parameter and the sticky err flag).
//
// Handshakes:
//   core side  - i_req is a level request; it is accepted in IDLE when
//                i_flush is low, and o_busy (combinational) stays high from
//                that cycle until the transaction completes. i_flush cancels
//                a request that has not yet been granted.
//   arbiter    - o_bus_req_ (active-low) is held low from acceptance until
//                completion so ownership cannot move mid-transaction;
//                i_bus_grnt_ low in REQ starts the data phase.
//   slave      - o_bus_as_ is low for exactly one cycle (ACCESS); the
//                transaction completes in the first ACCESS/WAIT cycle with
//                i_bus_rdy_ low. Once strobed, a transaction always finishes.
//   After completion one IDLE cycle with o_bus_req_ high always follows,
//   which lets the arbiter rotate priority.
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int unsigned ADDR_W = BUS_ADDR_W,
  parameter int unsigned DATA_W = BUS_DATA_W
`ifdef BUS_IF_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT_CYCLES
`endif
) (
  input  logic              clk,
  input  logic              reset,
  // core side
  input  logic              i_req,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rw,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_busy,
  output logic              o_err,
  // arbiter side
  output logic              o_bus_req_,
  input  logic              i_bus_grnt_,
  // bus side
  output logic              o_bus_as_,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic              o_bus_rw,
  output logic [DATA_W-1:0] o_bus_wr_data,
  input  logic [DATA_W-1:0] i_bus_rd_data,
  input  logic              i_bus_rdy_,
  // debug: current FSM state
  output logic [1:0]        o_state
);

  bus_if_state_e     r_state;
  logic              r_bus_req_n;
  logic              r_bus_as_n;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_err;

  bus_if_state_e     w_state_next;
  logic              w_bus_req_n_next;
  logic              w_bus_as_n_next;
  logic [DATA_W-1:0] w_rd_data_next;
  logic              w_err_next;
  logic              w_latch;
  logic              w_owns;
  logic              w_expire;

  assign w_owns = bus_if_owns_bus(r_state);

`ifdef BUS_IF_TIMEOUT_EN
  // REQ -> ACCESS transition, recomputed from inputs to keep the watchdog
  // clear independent of the next-state logic that consumes w_expire.
  logic w_enter_access;
  assign w_enter_access = (r_state == BUS_IF_STATE_REQ) && !i_flush && !i_bus_grnt_;

  bus_master_if_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_enter_access),
    .i_count  (w_owns),
    .o_expire (w_expire)
  );
`else
  // No watchdog: WAIT holds until the slave answers, err can never set.
  assign w_expire = 1'b0;
`endif

  // Next-state and next-register-value logic for the requester FSM.
  always_comb begin
    w_state_next     = r_state;
    w_bus_req_n_next = r_bus_req_n;
    w_bus_as_n_next  = r_bus_as_n;
    w_rd_data_next   = r_rd_data;
    w_err_next       = r_err;
    w_latch          = 1'b0;
    case (r_state)
      BUS_IF_STATE_IDLE: begin
        if (i_req && !i_flush) begin
          w_latch          = 1'b1;
          w_bus_req_n_next = 1'b0;
          w_err_next       = 1'b0;
          w_state_next     = BUS_IF_STATE_REQ;
        end
      end
      BUS_IF_STATE_REQ: begin
        // A flush arriving with the grant still cancels: nothing was strobed.
        if (i_flush) begin
          w_bus_req_n_next = 1'b1;
          w_state_next     = BUS_IF_STATE_IDLE;
        end else if (!i_bus_grnt_) begin
          w_bus_as_n_next  = 1'b0;
          w_state_next     = BUS_IF_STATE_ACCESS;
        end
      end
      BUS_IF_STATE_ACCESS, BUS_IF_STATE_WAIT: begin
        // Strobe lasts only the ACCESS cycle; flush is ignored from here on.
        w_bus_as_n_next = 1'b1;
        if (!i_bus_rdy_) begin
          // Ready on the limit cycle still counts as success.
          w_bus_req_n_next = 1'b1;
          if (r_rw == BUS_READ) begin
            w_rd_data_next = i_bus_rd_data;
          end
          w_state_next = BUS_IF_STATE_IDLE;
        end else if (w_expire) begin
          w_bus_req_n_next = 1'b1;
          w_err_next       = 1'b1;
          w_state_next     = BUS_IF_STATE_IDLE;
        end else begin
          w_state_next = BUS_IF_STATE_WAIT;
        end
      end
      default: begin
        w_bus_req_n_next = 1'b1;
        w_bus_as_n_next  = 1'b1;
        w_state_next     = BUS_IF_STATE_IDLE;
      end
    endcase
  end

  // State and handshake registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= BUS_IF_STATE_IDLE;
      r_bus_req_n <= 1'b1;
      r_bus_as_n  <= 1'b1;
      r_rd_data   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bus_req_n <= w_bus_req_n_next;
      r_bus_as_n  <= w_bus_as_n_next;
      r_rd_data   <= w_rd_data_next;
      r_err       <= w_err_next;
    end
  end

  // Access capture: address, direction and write data held for the whole
  // transaction so the bus lines stay stable through WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= '0;
      r_rw      <= BUS_READ;
      r_wr_data <= '0;
    end else if (w_latch) begin
      r_addr    <= i_addr;
      r_rw      <= i_rw;
      r_wr_data <= i_wr_data;
    end
  end

  // Bus lines carry the access only while this master owns the data phase;
  // otherwise they sit at 0 / READ / 0 so the shared OR/mux stays clean.
  assign o_bus_addr    = w_owns ? r_addr    : '0;
  assign o_bus_rw      = w_owns ? r_rw      : BUS_READ;
  assign o_bus_wr_data = w_owns ? r_wr_data : '0;

  assign o_bus_req_ = r_bus_req_n;
  assign o_bus_as_  = r_bus_as_n;
  assign o_rd_data  = r_rd_data;
  assign o_err      = r_err;
  assign o_busy     = (r_state != BUS_IF_STATE_IDLE) ||
                      ((r_state == BUS_IF_STATE_IDLE) && i_req && !i_flush);
  assign o_state    = r_state;

endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if: directed bench for bus_master_if. Inputs are driven 1
// time unit after the rising edge and outputs are sampled 1 unit later.
// Define BUS_IF_TIMEOUT_EN to also exercise the watchdog (limit 8).
module tb_bus_master_if;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  logic        clk;
  logic        reset;
  logic        req;
  logic        flush;
  logic [29:0] addr;
  logic        rw;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        busy;
  logic        err;
  logic        bus_req_;
  logic        bus_grnt_;
  logic        bus_as_;
  logic [29:0] bus_addr;
  logic        bus_rw;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;
  logic [1:0]  state;

  int          n_cmp;
  int          n_err;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  bus_master_if #(
    .ADDR_W(30),
    .DATA_W(32)
`ifdef BUS_IF_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_req         (req),
    .i_flush       (flush),
    .i_addr        (addr),
    .i_rw          (rw),
    .i_wr_data     (wr_data),
    .o_rd_data     (rd_data),
    .o_busy        (busy),
    .o_err         (err),
    .o_bus_req_    (bus_req_),
    .i_bus_grnt_   (bus_grnt_),
    .o_bus_as_     (bus_as_),
    .o_bus_addr    (bus_addr),
    .o_bus_rw      (bus_rw),
    .o_bus_wr_data (bus_wr_data),
    .i_bus_rd_data (bus_rd_data),
    .i_bus_rdy_    (bus_rdy_),
    .o_state       (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "bench watchdog expired");
  end

  // checker
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic is_rd, input logic [29:0] a, input logic [31:0] d);
    req     = 1'b1;
    rw      = is_rd;
    addr    = a;
    wr_data = d;
  endtask

  // scoreboard: expected read data pushed when a read's slave data is set up
  task automatic check_read_done(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got empty queue expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_val(tag, 64'(rd_data), 64'(e));
      last_rd = e;
    end
  endtask

  initial begin
    logic [6:0] v_req;
    logic [6:0] v_as;
    logic [6:0] v_busy;
    n_cmp       = 0;
    n_err       = 0;
    last_rd     = '0;
    reset       = 1'b1;
    req         = 1'b0;
    flush       = 1'b0;
    addr        = '0;
    rw          = 1'b1;
    wr_data     = '0;
    bus_grnt_   = 1'b1;
    bus_rd_data = '0;
    bus_rdy_    = 1'b1;

    // reset state
    next_cycle();
    next_cycle();
    check_val("rst_state", 64'(state), 64'(S_IDLE));
    check_val("rst_bus_req_", 64'(bus_req_), 64'd1);
    check_val("rst_bus_as_", 64'(bus_as_), 64'd1);
    check_val("rst_bus_addr", 64'(bus_addr), 64'd0);
    check_val("rst_bus_rw", 64'(bus_rw), 64'd1);
    check_val("rst_bus_wr_data", 64'(bus_wr_data), 64'd0);
    check_val("rst_rd_data", 64'(rd_data), 64'd0);
    check_val("rst_err", 64'(err), 64'd0);
    check_val("rst_busy_lo", 64'(busy), 64'd0);
    req = 1'b1;
    settle();
    check_val("rst_busy_follows_req", 64'(busy), 64'd1);
    req = 1'b0;
    next_cycle();
    reset = 1'b0;

    // best-case read: grant held, ready in strobe cycle
    bus_grnt_   = 1'b0;
    bus_rdy_    = 1'b0;
    bus_rd_data = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    next_cycle();
    issue(1'b1, 30'h2A, 32'h0);
    settle();
    check_val("rd_c0_busy", 64'(busy), 64'd1);
    check_val("rd_c0_bus_req_", 64'(bus_req_), 64'd1);
    next_cycle();
    req = 1'b0;
    settle();
    check_val("rd_c1_state", 64'(state), 64'(S_REQ));
    check_val("rd_c1_bus_req_", 64'(bus_req_), 64'd0);
    check_val("rd_c1_bus_as_", 64'(bus_as_), 64'd1);
    check_val("rd_c1_bus_addr", 64'(bus_addr), 64'd0);
    next_cycle();
    check_val("rd_c2_bus_as_", 64'(bus_as_), 64'd0);
    check_val("rd_c2_bus_addr", 64'(bus_addr), 64'h2A);
    check_val("rd_c2_bus_rw", 64'(bus_rw), 64'd1);
    check_val("rd_c2_busy", 64'(busy), 64'd1);
    next_cycle();
    check_read_done("rd_c3_rd_data");
    check_val("rd_c3_busy", 64'(busy), 64'd0);
    check_val("rd_c3_bus_req_", 64'(bus_req_), 64'd1);
    check_val("rd_c3_bus_as_", 64'(bus_as_), 64'd1);

    // write with four wait cycles
    next_cycle();
    issue(1'b0, 30'h100, 32'h12345678);
    bus_rdy_    = 1'b1;
    bus_rd_data = 32'hCAFEF00D;
    next_cycle();
    req = 1'b0;
    next_cycle();
    settle();
    check_val("wr_access_bus_as_", 64'(bus_as_), 64'd0);
    check_val("wr_access_bus_rw", 64'(bus_rw), 64'd0);
    for (int w = 0; w < 4; w++) begin
      next_cycle();
      if (w == 3) bus_rdy_ = 1'b0;
      settle();
      check_val($sformatf("wr_wait%0d_state", w), 64'(state), 64'(S_WAIT));
      check_val($sformatf("wr_wait%0d_bus_as_", w), 64'(bus_as_), 64'd1);
      check_val($sformatf("wr_wait%0d_bus_req_", w), 64'(bus_req_), 64'd0);
      check_val($sformatf("wr_wait%0d_bus_addr", w), 64'(bus_addr), 64'h100);
      check_val($sformatf("wr_wait%0d_bus_rw", w), 64'(bus_rw), 64'd0);
      check_val($sformatf("wr_wait%0d_bus_wr_data", w), 64'(bus_wr_data), 64'h12345678);
    end
    next_cycle();
    check_val("wr_done_state", 64'(state), 64'(S_IDLE));
    check_val("wr_done_rd_data", 64'(rd_data), 64'(last_rd));
    check_val("wr_done_busy", 64'(busy), 64'd0);
    check_val("wr_done_bus_addr", 64'(bus_addr), 64'd0);
    check_val("wr_done_bus_rw", 64'(bus_rw), 64'd1);
    check_val("wr_done_bus_wr_data", 64'(bus_wr_data), 64'd0);

    // flush while grant withheld; flush beats a same-cycle grant
    bus_grnt_ = 1'b1;
    next_cycle();
    issue(1'b1, 30'h3, 32'h0);
    next_cycle();
    req = 1'b0;
    settle();
    check_val("fl_c1_bus_req_", 64'(bus_req_), 64'd0);
    next_cycle();
    check_val("fl_c2_state", 64'(state), 64'(S_REQ));
    next_cycle();
    flush     = 1'b1;
    bus_grnt_ = 1'b0;
    settle();
    check_val("fl_c3_busy", 64'(busy), 64'd1);
    next_cycle();
    flush = 1'b0;
    settle();
    check_val("fl_c4_state", 64'(state), 64'(S_IDLE));
    check_val("fl_c4_bus_req_", 64'(bus_req_), 64'd1);
    check_val("fl_c4_bus_as_", 64'(bus_as_), 64'd1);
    check_val("fl_c4_busy", 64'(busy), 64'd0);
    next_cycle();
    check_val("fl_c5_bus_as_", 64'(bus_as_), 64'd1);
    // request together with flush in IDLE is not accepted
    req   = 1'b1;
    flush = 1'b1;
    settle();
    check_val("fl_idle_busy", 64'(busy), 64'd0);
    next_cycle();
    check_val("fl_idle_state", 64'(state), 64'(S_IDLE));
    check_val("fl_idle_bus_req_", 64'(bus_req_), 64'd1);
    req   = 1'b0;
    flush = 1'b0;

    // back-to-back reads with req held: one bus_req_ high cycle between
    bus_grnt_   = 1'b0;
    bus_rdy_    = 1'b0;
    bus_rd_data = 32'h0BADF00D;
    exp_q.push_back(32'h0BADF00D);
    exp_q.push_back(32'h0BADF00D);
    v_req  = 7'b1001001;
    v_as   = 7'b1011011;
    v_busy = 7'b0111111;
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      if (c < 6) issue(1'b1, 30'h40, 32'h0);
      else req = 1'b0;
      settle();
      check_val($sformatf("b2b_c%0d_bus_req_", c), 64'(bus_req_), 64'(v_req[c]));
      check_val($sformatf("b2b_c%0d_bus_as_", c), 64'(bus_as_), 64'(v_as[c]));
      check_val($sformatf("b2b_c%0d_busy", c), 64'(busy), 64'(v_busy[c]));
      if (c == 3 || c == 6) check_read_done($sformatf("b2b_c%0d_rd_data", c));
    end

`ifdef BUS_IF_TIMEOUT_EN
    // watchdog abort after 8 data-phase cycles, err cleared by next request
    bus_rdy_ = 1'b1;
    next_cycle();
    issue(1'b1, 30'h77, 32'h0);
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      req = 1'b0;
      settle();
      if (c == 9) begin
        check_val("to_c9_state", 64'(state), 64'(S_WAIT));
        check_val("to_c9_err", 64'(err), 64'd0);
      end
      if (c == 10) begin
        check_val("to_c10_state", 64'(state), 64'(S_IDLE));
        check_val("to_c10_err", 64'(err), 64'd1);
        check_val("to_c10_bus_req_", 64'(bus_req_), 64'd1);
        check_val("to_c10_rd_data", 64'(rd_data), 64'(last_rd));
      end
    end
    next_cycle();
    issue(1'b0, 30'h78, 32'h5);
    next_cycle();
    req = 1'b0;
    bus_rdy_ = 1'b0;
    settle();
    check_val("to_err_cleared", 64'(err), 64'd0);
    next_cycle();
    next_cycle();
    check_val("to_after_state", 64'(state), 64'(S_IDLE));
`else
    check_val("no_to_err", 64'(err), 64'd0);
`endif

    // reset while in WAIT drops the transaction
    bus_grnt_ = 1'b0;
    bus_rdy_  = 1'b1;
    next_cycle();
    issue(1'b0, 30'h55, 32'hAAAA);
    next_cycle();
    req = 1'b0;
    next_cycle();
    next_cycle();
    check_val("rw_pre_state", 64'(state), 64'(S_WAIT));
    reset = 1'b1;
    next_cycle();
    check_val("rw_state", 64'(state), 64'(S_IDLE));
    check_val("rw_bus_req_", 64'(bus_req_), 64'd1);
    check_val("rw_bus_as_", 64'(bus_as_), 64'd1);
    check_val("rw_bus_addr", 64'(bus_addr), 64'd0);
    check_val("rw_rd_data", 64'(rd_data), 64'd0);
    reset = 1'b0;

    check_val("sb_queue_empty", 64'(exp_q.size()), 64'd0);

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_master_if.md
# bus_master_if

Master-side bus interface: the requester that sits opposite the 4-master round-robin bus arbiter. It turns a core-side access request into an arbiter request/grant handshake, then a single bus transaction with address strobe and slave ready, and returns read data. Each master port (CPU fetch, CPU data, DMA) instantiates one copy, wired to one `mN_req_`/`mN_grnt_` pair of the arbiter.

## Interface
- `ADDR_W`, 30, word-address width
- `DATA_W`, 32, data width
- `TIMEOUT_CYCLES`, 255, max cycles in ACCESS+WAIT before abort (only with `BUS_IF_TIMEOUT_EN`)

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `req`  in  1  core access request, level; held until `busy` falls
- `flush`  in  1  cancel a request not yet granted
- `addr`  in  ADDR_W  access address
- `rw`  in  1  1 = read, 0 = write
- `wr_data`  in  DATA_W  write data
- `rd_data`  out  DATA_W  read data of last completed read
- `busy`  out  1  access in progress, core must stall
- `err`  out  1  last access timed out (sticky)
- `bus_req_`  out  1  request to arbiter, active-low
- `bus_grnt_`  in  1  grant from arbiter, active-low
- `bus_as_`  out  1  address strobe, active-low
- `bus_addr`  out  ADDR_W  bus address
- `bus_rw`  out  1  bus direction, 1 = read
- `bus_wr_data`  out  DATA_W  bus write data
- `bus_rd_data`  in  DATA_W  slave read data
- `bus_rdy_`  in  1  slave ready, active-low

## Operation
- States: IDLE, REQ, ACCESS, WAIT.
- IDLE: `req & ~flush` -> latch `addr`/`rw`/`wr_data`, `bus_req_`<=0, clear `err`, -> REQ. Otherwise stay.
- REQ: `flush` -> `bus_req_`<=1, -> IDLE (flush wins over grant same cycle). Else `bus_grnt_`==0 -> `bus_as_`<=0, -> ACCESS. Else stay.
- ACCESS: `bus_as_`<=1 on exit. `bus_rdy_`==0 -> complete. Else -> WAIT.
- WAIT: `bus_rdy_`==0 -> complete. Else stay.
- Complete: `bus_req_`<=1; if read, `rd_data`<=`bus_rd_data`; -> IDLE. Write leaves `rd_data` unchanged.
- `flush` ignored in ACCESS/WAIT: a started bus transaction always completes.
- `bus_addr`/`bus_rw`/`bus_wr_data` drive latched values only in ACCESS/WAIT; otherwise 0 / 1 (read) / 0, so the bus OR/mux stays clean when not owner.
- `busy` = (state != IDLE) | (state == IDLE & `req` & ~`flush`), combinational.
- `bus_req_` held low through ACCESS/WAIT, so the arbiter cannot switch owner mid-transaction.

## Timing
- Reset values: state IDLE, `bus_req_`=1, `bus_as_`=1, `bus_addr`=0, `bus_rw`=1, `bus_wr_data`=0, `rd_data`=0, `err`=0, `busy` follows `req`.
- Best case (grant already held, slave ready in strobe cycle): req at cycle 0; `bus_req_` low at 1; `bus_as_` low at 2; `rd_data` valid and `busy` low at 3.
- `bus_as_` is low for exactly one cycle per transaction.
- Back-to-back: at least one IDLE cycle with `bus_req_`=1 between transactions, letting round-robin rotate.
- Reset mid-transaction: next edge releases `bus_req_`/`bus_as_`; transaction is dropped.

## Configuration
- `BUS_IF_TIMEOUT_EN` defined: counter cleared on entry to ACCESS, increments each ACCESS/WAIT cycle. Reaching `TIMEOUT_CYCLES` without `bus_rdy_` causes abort: `bus_req_`<=1, `err`<=1, `rd_data` unchanged, -> IDLE. `rdy_` in the same cycle as the limit counts as success.
- Not defined: no counter; WAIT holds indefinitely; `err` tied 0.

## Structure
- `bus.h` holds state encodings (`BUS_IF_STATE_*`, 2 bits), `BUS_READ`/`BUS_WRITE`, and address/data width macros.
- Optional sub-module `bus_if_timeout` (counter + expire flag), instantiated only under `BUS_IF_TIMEOUT_EN`.

## Test plan
- Read, grant immediate, `bus_rdy_` low in strobe cycle, `bus_rd_data`=0xDEADBEEF -> `rd_data`=0xDEADBEEF and `busy` low 3 cycles after `req`.
- Write addr 0x100, data 0x12345678, `rdy_` after 4 wait cycles -> `bus_as_` low 1 cycle, bus lines stable through WAIT, `rd_data` unchanged.
- Grant withheld 5 cycles, `flush` at cycle 3 -> `bus_req_` high next cycle, no `bus_as_`, `busy` low.
- Two masters with arbiter: back-to-back `req` -> `bus_req_` high ≥1 cycle between transactions, other master granted.
- With `BUS_IF_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, `rdy_` never asserted -> abort after 8 cycles, `err`=1, next accepted `req` clears `err`.
- Reset asserted in WAIT -> `bus_req_`=1, `bus_as_`=1, state IDLE next cycle.
